// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - GF(2^8) field constants, symbol type and evaluator FSM states
package gf_pkg;
  localparam int         GF_SIZE      = 8;
  localparam logic [8:0] GF_PRIM_POLY = 9'h11D;

  typedef logic [GF_SIZE-1:0] gf_sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gf_state_e;
endpackage

// File: rtl/gf_mult.sv
// rtl/gf_mult.sv - combinational GF(2^8) multiplier, carry-less product reduced by 0x11D
module gf_mult
  import gf_pkg::*;
(
  input  logic [GF_SIZE-1:0] a_i,
  input  logic [GF_SIZE-1:0] b_i,
  output logic [GF_SIZE-1:0] p_o
);

  logic [2*GF_SIZE-2:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < GF_SIZE; i++) begin
      if (b_i[i]) prod = prod ^ ({{(GF_SIZE-1){1'b0}}, a_i} << i);
    end
    // Fold the high bits back from the top down so each step clears one bit.
    for (int k = 2*GF_SIZE-2; k >= GF_SIZE; k--) begin
      if (prod[k]) prod = prod ^ ({{(GF_SIZE-2){1'b0}}, GF_PRIM_POLY} << (k-GF_SIZE));
    end
    p_o = prod[GF_SIZE-1:0];
  end

endmodule

// File: rtl/gf_poly_eval.sv
// rtl/gf_poly_eval.sv - sequential Horner evaluator over GF(2^8); optional GF_POLY_EVAL_ZERO_FLAG_EN adds out_zero
module gf_poly_eval
  import gf_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [(N+1)*GF_SIZE-1:0] flat_p,
  input  logic [GF_SIZE-1:0]       x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [GF_SIZE-1:0]       result
`ifdef GF_POLY_EVAL_ZERO_FLAG_EN
  ,
  output logic                     out_zero
`endif
);

  localparam int IDX_W = (N < 2) ? 1 : $clog2(N+1);

  gf_state_e        state_q, state_d;
  gf_sym_t          acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  gf_sym_t          x_q, x_d;
  gf_sym_t          p_q [0:N];
  gf_sym_t          p_d [0:N];
  gf_sym_t          prod;
  logic             acc_en;

  gf_mult u_gf_mult (
    .a_i (acc_q),
    .b_i (x_q),
    .p_o (prod)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    x_d     = x_q;
    acc_en  = 1'b0;
    for (int i = 0; i <= N; i++) p_d[i] = p_q[i];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i <= N; i++) p_d[i] = flat_p[i*GF_SIZE +: GF_SIZE];
          x_d     = x;
          acc_d   = flat_p[N*GF_SIZE +: GF_SIZE];
          acc_en  = 1'b1;
          idx_d   = IDX_W'(N-1);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = prod ^ p_q[idx_q];
        acc_en = 1'b1;
        if (idx_q == '0) state_d = DONE;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      for (int i = 0; i <= N; i++) p_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      for (int i = 0; i <= N; i++) p_q[i] <= p_d[i];
    end
  end

`ifdef GF_POLY_EVAL_ZERO_FLAG_EN
  logic zero_q;

  // Tracks acc only when acc is written, so it reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      zero_q <= 1'b0;
    else if (acc_en) zero_q <= (acc_d == '0);
  end

  assign out_zero = zero_q;
`else
  logic unused_acc_en;
  assign unused_acc_en = acc_en;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;

endmodule

// File: tb/tb_gf_poly_eval.sv
// tb/tb_gf_poly_eval.sv - scoreboard bench for gf_poly_eval (n=2)
module tb_gf_poly_eval;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [23:0]     flat_p = '0;
  logic [7:0]      x = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [7:0]      result;
`ifdef GF_POLY_EVAL_ZERO_FLAG_EN
  logic            out_zero;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  gf_poly_eval #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flat_p    (flat_p),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef GF_POLY_EVAL_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] aa = a;
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return r;
  endfunction

  // Power-sum form sum(p[i] * x^i), independent of the DUT's Horner order.
  function automatic logic [7:0] m_eval(input logic [23:0] fp, input logic [7:0] xv);
    logic [7:0] sum = 8'h00;
    logic [7:0] pw = 8'h01;
    for (int i = 0; i <= N; i++) begin
      sum ^= m_mul(fp[i*8 +: 8], pw);
      pw = m_mul(pw, xv);
    end
    return sum;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_eval(input logic [23:0] fp, input logic [7:0] xv, input logic [7:0] exp);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    flat_p   = fp;
    x        = xv;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 32'(guard < 50), 32'd1);
    sb.push_back(exp);
  endtask

  // Counts rising edges from the accept edge (inclusive) until out_valid.
  task automatic wait_done(input string tag);
    int lat = 0;
    do begin
      @(posedge clk);
      #1;
      if (lat == 0) in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'(N+1));
  endtask

  task automatic consume(input string tag);
    logic [7:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp));
`ifdef GF_POLY_EVAL_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(out_zero), 32'(exp == 8'h00));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic eval(input string tag, input logic [23:0] fp, input logic [7:0] xv, input logic [7:0] exp);
    start_eval(fp, xv, exp);
    wait_done(tag);
    consume(tag);
  endtask

  initial begin
    logic [7:0]  held;
    logic [23:0] hold_fp;
    logic [7:0]  hold_x;
    logic [23:0] rfp;
    logic [7:0]  rx;
    int          stray;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
`ifdef GF_POLY_EVAL_ZERO_FLAG_EN
    check("rst_zero", 32'(out_zero), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("early_ready_no_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    eval("x0",    24'h020407, 8'h00, 8'h07);
    eval("x1",    24'h020407, 8'h01, 8'h01);
    eval("x2",    24'h020407, 8'h02, 8'h07);
    eval("x3",    24'h020407, 8'h03, 8'h01);
    eval("reduce", 24'h000200, 8'h80, 8'h1D);
    eval("allzero", 24'h000000, 8'h5A, 8'h00);
    eval("model_x3", 24'h020407, 8'h03, m_eval(24'h020407, 8'h03));

    for (int i = 0; i < 6; i++) begin
      rfp = 24'($urandom);
      rx  = 8'($urandom);
      eval($sformatf("rand%0d", i), rfp, rx, m_eval(rfp, rx));
    end

    // Stall in DONE while the upstream keeps changing its offer.
    start_eval(24'h112233, 8'h44, m_eval(24'h112233, 8'h44));
    wait_done("hold");
    held = result;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      flat_p   = 24'($urandom);
      x        = 8'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("hold_result%0d", c), 32'(result), 32'(held));
      check($sformatf("hold_in_ready%0d", c), 32'(in_ready), 32'd0);
      check($sformatf("hold_valid%0d", c), 32'(out_valid), 32'd1);
    end
    hold_fp = flat_p;
    hold_x  = x;
    consume("hold");
    check("hold_in_ready_after", 32'(in_ready), 32'd1);
    sb.push_back(m_eval(hold_fp, hold_x));
    wait_done("hold_next");
    consume("hold_next");

    // Reset while the second CALC cycle is in progress.
    start_eval(24'h0A0B0C, 8'h0D, m_eval(24'h0A0B0C, 8'h0D));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", 32'(result), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) stray++;
    end
    check("midrst_no_valid", 32'(stray), 32'd0);
    eval("after_rst", 24'h020407, 8'h02, 8'h07);
    eval("after_rst_model", 24'h0A0B0C, 8'h0D, m_eval(24'h0A0B0C, 8'h0D));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
